// File: rtl/xup_mux_pkg.sv
// Shared types and helpers for the scanning multiplexer.
// Holds the mode enum and an elaboration-time log2 for index widths.
package xup_mux_pkg;

    typedef enum logic [1:0] {
        StManual = 2'd0,
        StScan   = 2'd1,
        StStall  = 2'd2
    } state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((32'd1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/xup_rr_next.sv
// Rotating-priority search: first set bit of mask at or after start, wrapping modulo N.
// found is low only when the mask is empty.
module xup_rr_next
    import xup_mux_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]          mask,
    input  logic [clog2(N)-1:0]   start,
    output logic [clog2(N)-1:0]   next,
    output logic                  found
);

    localparam int unsigned SELW = clog2(N);

    // Modulo-N add that also works when N is not a power of two.
    function automatic logic [SELW-1:0] wrap(input logic [SELW-1:0] base,
                                             input int unsigned     off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= N) begin
            sum = sum - N;
        end
        return SELW'(sum);
    endfunction

    logic [SELW-1:0] idx;

    always_comb begin
        next  = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = wrap(start, i);
            if (!found && mask[idx]) begin
                found = 1'b1;
                next  = idx;
            end
        end
    end

endmodule

// File: rtl/xup_scan_mux.sv
// Registered N-to-1 multiplexer with manual channel select and round-robin auto-scan
// over the enabled channels, DWELL clocks per channel, stalling when no channel is enabled.
module xup_scan_mux
    import xup_mux_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DWELL = 4,
    parameter int unsigned DELAY = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N*WIDTH-1:0]    din,
    input  logic [clog2(N)-1:0]   sel,
    input  logic                  sel_load,
    input  logic                  scan_en,
    input  logic [N-1:0]          ch_mask,
    output logic [WIDTH-1:0]      y,
    output logic                  y_valid,
    output logic [clog2(N)-1:0]   cur_ch,
    output logic                  advance
);

    localparam int unsigned SELW = clog2(N);
    localparam int unsigned CNTW = clog2(DWELL) + 1;
    localparam logic [CNTW-1:0] DwellLast = CNTW'(DWELL - 1);

    // Output delay is a simulation nicety only; the RTL outputs are undelayed.
    if (DELAY != 0) begin : g_delay_unmodelled
    end

    state_e            state_q, state_d;
    logic [SELW-1:0]   cur_ch_q, cur_ch_d;
    logic [CNTW-1:0]   dwell_q, dwell_d;
    logic [WIDTH-1:0]  y_q, y_d;
    logic              y_valid_q, y_valid_d;
    logic              advance_q, advance_d;

    logic [SELW-1:0]   cur_ch_inc;
    logic [SELW-1:0]   rr_start;
    logic [SELW-1:0]   rr_next;
    logic              rr_found;
    logic              sel_ok;

    assign cur_ch_inc = (cur_ch_q == SELW'(N - 1)) ? '0 : cur_ch_q + SELW'(1);
    assign sel_ok     = (32'(sel) < N) && ch_mask[sel];

    // STALL exit may land on cur_ch itself; dwell expiry looks past it first.
    assign rr_start = (state_q == StStall) ? cur_ch_q : cur_ch_inc;

    xup_rr_next #(
        .N(N)
    ) u_rr_next (
        .mask  (ch_mask),
        .start (rr_start),
        .next  (rr_next),
        .found (rr_found)
    );

    always_comb begin
        y_valid_d = ch_mask[cur_ch_q];
        y_d       = ch_mask[cur_ch_q] ? din[32'(cur_ch_q) * WIDTH +: WIDTH] : '0;
    end

    always_comb begin
        state_d   = state_q;
        cur_ch_d  = cur_ch_q;
        dwell_d   = dwell_q;
        advance_d = 1'b0;
        unique case (state_q)
            StManual: begin
                if (scan_en) begin
                    state_d = StScan;
                    dwell_d = '0;
                end else if (sel_load && sel_ok) begin
                    cur_ch_d = sel;
                end
            end
            StScan: begin
                if (!scan_en) begin
                    state_d = StManual;
                    dwell_d = '0;
                end else if (ch_mask == '0) begin
                    state_d = StStall;
                    dwell_d = '0;
                end else if (!ch_mask[cur_ch_q] || (dwell_q == DwellLast)) begin
                    // Search wraps back to cur_ch, so a lone enabled channel re-dwells.
                    if (rr_found) begin
                        cur_ch_d = rr_next;
                    end
                    dwell_d   = '0;
                    advance_d = 1'b1;
                end else begin
                    dwell_d = dwell_q + CNTW'(1);
                end
            end
            StStall: begin
                if (!scan_en) begin
                    state_d = StManual;
                end else if (rr_found) begin
                    cur_ch_d = rr_next;
                    state_d  = StScan;
                    dwell_d  = '0;
                end
            end
            default: begin
                state_d = StManual;
                dwell_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StManual;
            cur_ch_q  <= '0;
            dwell_q   <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
            advance_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_ch_q  <= cur_ch_d;
            dwell_q   <= dwell_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            advance_q <= advance_d;
        end
    end

    assign y       = y_q;
    assign y_valid = y_valid_q;
    assign cur_ch  = cur_ch_q;
    assign advance = advance_q;

endmodule

// File: tb/tb_xup_scan_mux.sv
// Scoreboard bench for xup_scan_mux: a behavioural model predicts each cycle's outputs,
// queues them as inputs are driven, and compares once the DUT has clocked.
module tb_xup_scan_mux;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 8;
    localparam int unsigned DW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   din = 32'hDDCC_BBAA;
    logic [1:0]    sel;
    logic          sel_load;
    logic          scan_en;
    logic [3:0]    ch_mask;
    logic [7:0]    y;
    logic          y_valid;
    logic [1:0]    cur_ch;
    logic          advance;

    always #5 clk = ~clk;

    xup_scan_mux #(
        .N     (N),
        .WIDTH (W),
        .DWELL (DW),
        .DELAY (0)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .din      (din),
        .sel      (sel),
        .sel_load (sel_load),
        .scan_en  (scan_en),
        .ch_mask  (ch_mask),
        .y        (y),
        .y_valid  (y_valid),
        .cur_ch   (cur_ch),
        .advance  (advance)
    );

    typedef struct packed {
        logic [1:0] ch;
        logic [7:0] y;
        logic       v;
        logic       adv;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    // Model state: 0 manual, 1 scan, 2 stall.
    int m_state = 0;
    int m_ch    = 0;
    int m_dwell = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int find_en(input int start, input int off);
        int c;
        for (int k = off; k < off + int'(N); k++) begin
            c = (start + k) % int'(N);
            if (ch_mask[c]) return c;
        end
        return start;
    endfunction

    // Predict the next edge from current inputs, queue it, clock, then compare.
    task automatic step(input string tag);
        exp_t e;
        int   nch, nd, ns;
        logic nadv;
        logic [7:0] dv;
        dv    = din[m_ch*8 +: 8];
        e.v   = ch_mask[m_ch];
        e.y   = ch_mask[m_ch] ? dv : 8'h00;
        nch   = m_ch;
        nd    = m_dwell;
        ns    = m_state;
        nadv  = 1'b0;
        case (m_state)
            0: begin
                if (scan_en) begin
                    ns = 1; nd = 0;
                end else if (sel_load && ch_mask[sel]) begin
                    nch = int'(sel);
                end
            end
            1: begin
                if (!scan_en) begin
                    ns = 0; nd = 0;
                end else if (ch_mask == 4'h0) begin
                    ns = 2; nd = 0;
                end else if (!ch_mask[m_ch] || m_dwell == int'(DW) - 1) begin
                    nch = find_en(m_ch, 1); nd = 0; nadv = 1'b1;
                end else begin
                    nd = m_dwell + 1;
                end
            end
            default: begin
                if (!scan_en) begin
                    ns = 0;
                end else if (ch_mask != 4'h0) begin
                    nch = find_en(m_ch, 0); ns = 1; nd = 0;
                end
            end
        endcase
        e.ch  = 2'(nch);
        e.adv = nadv;
        sb_q.push_back(e);
        m_ch = nch; m_dwell = nd; m_state = ns;
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_eq({tag, ".cur_ch"},  32'(cur_ch),  32'(e.ch));
        check_eq({tag, ".y"},       32'(y),       32'(e.y));
        check_eq({tag, ".y_valid"}, 32'(y_valid), 32'(e.v));
        check_eq({tag, ".advance"}, 32'(advance), 32'(e.adv));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, ".cur_ch"},  32'(cur_ch),  32'h0);
        check_eq({tag, ".y"},       32'(y),       32'h0);
        check_eq({tag, ".y_valid"}, 32'(y_valid), 32'h0);
        check_eq({tag, ".advance"}, 32'(advance), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        sel      = 2'd0;
        sel_load = 1'b0;
        scan_en  = 1'b0;
        ch_mask  = 4'hF;
        #3;
        check_reset_outputs("por");
        @(negedge clk);
        reset = 1'b0;

        // Manual load, then a load of a masked channel is ignored.
        sel = 2'd2; sel_load = 1'b1;
        step("t2_load2");
        sel_load = 1'b0;
        step("t2_y_cc");
        ch_mask = 4'b0111; sel = 2'd3; sel_load = 1'b1;
        step("t2_masked3");
        sel_load = 1'b0;
        step("t2_hold");

        // Park on ch0, then scan 1011.
        ch_mask = 4'hF; sel = 2'd0; sel_load = 1'b1;
        step("t3_park0");
        sel_load = 1'b0;
        ch_mask  = 4'b1011;
        scan_en  = 1'b1;
        for (int i = 0; i < 11; i++) step("t3_scan");

        // Drop the current channel mid-dwell on ch1.
        for (int i = 0; i < 12 && !(m_ch == 1 && m_dwell == 1); i++) step("t4_seek");
        check_eq("t4_on_ch1", 32'(cur_ch), 32'd1);
        ch_mask = 4'b1001;
        step("t4_drop1");
        for (int i = 0; i < 4; i++) step("t4_after");

        // Empty mask stalls; re-enabling ch2 resumes there.
        ch_mask = 4'h0;
        for (int i = 0; i < 3; i++) step("t5_stall");
        ch_mask = 4'b0100;
        for (int i = 0; i < 5; i++) step("t5_resume");

        // Asynchronous reset while scanning on ch2.
        ch_mask = 4'hF;
        for (int i = 0; i < 12 && !(m_ch == 2 && m_state == 1); i++) step("t1_seek");
        check_eq("t1_on_ch2", 32'(cur_ch), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("t1_async");
        m_state = 0; m_ch = 0; m_dwell = 0;
        @(negedge clk);
        reset = 1'b0;

        // Leaving scan mode wins over a simultaneous manual load.
        scan_en = 1'b1; ch_mask = 4'hF;
        for (int i = 0; i < 5; i++) step("t6_scan");
        scan_en = 1'b0; sel_load = 1'b1; sel = 2'(m_ch + 1);
        step("t6_exit");
        sel_load = 1'b0;
        step("t6_manual");
        sel_load = 1'b1;
        step("t6_load_ok");
        sel_load = 1'b0;

        // Random traffic against the model.
        for (int i = 0; i < 150; i++) begin
            ch_mask  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) ch_mask = 4'h0;
            if ($urandom_range(0, 7) == 0) scan_en = ~scan_en;
            sel      = 2'($urandom_range(0, 3));
            sel_load = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) != 0 && scan_en) ch_mask = ch_mask | 4'b0001;
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
